// File: rtl/fm_rx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fm_rx_pkg                                                        |
// | Shared width constants and tag type for the FM-receiver          |
// | multiplier arbiter.                                              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package fm_rx_pkg;

  localparam int FM_MUL_A_W     = 16;
  localparam int FM_MUL_B_W     = 16;
  localparam int FM_MUL_P_W     = 30;
  localparam int FM_MUL_MAX_REQ = 8;

  // One-hot owner tag; requesters use the low NUM_REQ bits.
  typedef logic [FM_MUL_MAX_REQ-1:0] fm_mul_tag_t;

endpackage
`default_nettype wire

// File: rtl/fm_receiver_mul_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fm_receiver_mul_arbiter_if                                       |
// | Request/result bus between FM-receiver kernels and the shared    |
// | multiplier arbiter.                                              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface fm_receiver_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int A_W     = fm_rx_pkg::FM_MUL_A_W,
  parameter int B_W     = fm_rx_pkg::FM_MUL_B_W,
  parameter int P_W     = fm_rx_pkg::FM_MUL_P_W
);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     res_valid;
  logic [P_W-1:0]         res_p;
  logic                   busy;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_p, busy
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_p, busy
  );

endinterface
`default_nettype wire

// File: rtl/fm_rx_mul_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fm_rx_mul_pipe                                                   |
// | MUL_STAGES-deep signed multiply pipeline carrying valid and tag. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fm_rx_mul_pipe
  import fm_rx_pkg::*;
#(
  parameter int MUL_STAGES = 3,
  parameter int A_W        = FM_MUL_A_W,
  parameter int B_W        = FM_MUL_B_W,
  parameter int P_W        = FM_MUL_P_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  i_valid,
  input  fm_mul_tag_t           i_tag,
  input  logic signed [A_W-1:0] i_a,
  input  logic signed [B_W-1:0] i_b,
  output logic                  o_valid,
  output fm_mul_tag_t           o_tag,
  output logic signed [P_W-1:0] o_p,
  output logic [MUL_STAGES-1:0] o_stage_valid
);

  localparam int c_FULL_W = A_W + B_W;

  logic [MUL_STAGES-1:0] r_vld;
  fm_mul_tag_t           r_tag [MUL_STAGES];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_vld <= '0;
      for (int s = 0; s < MUL_STAGES; s++) r_tag[s] <= '0;
    end else begin
      r_vld[0] <= i_valid;
      r_tag[0] <= i_tag;
      for (int s = 1; s < MUL_STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign o_valid       = r_vld[MUL_STAGES-1];
  assign o_tag         = r_tag[MUL_STAGES-1];
  assign o_stage_valid = r_vld;

  generate
    if (MUL_STAGES == 1) begin : g_single
      logic signed [c_FULL_W-1:0] w_full;
      logic signed [P_W-1:0]      r_p;
      logic                       w_unused_full;

      assign w_full        = c_FULL_W'(i_a) * c_FULL_W'(i_b);
      assign w_unused_full = ^w_full;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          r_p <= '0;
        end else if (i_valid) begin
          r_p <= w_full[P_W-1:0];
        end
      end

      assign o_p = r_p;
    end else begin : g_multi
      logic signed [A_W-1:0]      r_a;
      logic signed [B_W-1:0]      r_b;
      logic signed [c_FULL_W-1:0] w_full;
      logic signed [P_W-1:0]      r_prod [1:MUL_STAGES-1];
      logic                       w_unused_full;

      // Operand registers feed the multiplier; product stages follow.
      assign w_full        = c_FULL_W'(r_a) * c_FULL_W'(r_b);
      assign w_unused_full = ^w_full;

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          r_a <= '0;
          r_b <= '0;
          for (int s = 1; s < MUL_STAGES; s++) r_prod[s] <= '0;
        end else begin
          r_a <= i_a;
          r_b <= i_b;
          // Only the output stage holds across bubbles so res_p keeps its last value.
          if (MUL_STAGES > 2 || r_vld[0]) begin
            r_prod[1] <= w_full[P_W-1:0];
          end
          for (int s = 2; s < MUL_STAGES; s++) begin
            if (s < MUL_STAGES - 1 || r_vld[s-1]) begin
              r_prod[s] <= r_prod[s-1];
            end
          end
        end
      end

      assign o_p = r_prod[MUL_STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fm_receiver_mul_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fm_receiver_mul_arbiter                                          |
// | Round-robin arbiter sharing one pipelined signed multiplier      |
// | among FM-receiver kernels. Optional macro FM_MUL_ARB_PRIO_EN     |
// | gives requester 0 strict priority.                               |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module fm_receiver_mul_arbiter
  import fm_rx_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int MUL_STAGES = 3,
  parameter int A_W        = FM_MUL_A_W,
  parameter int B_W        = FM_MUL_B_W,
  parameter int P_W        = FM_MUL_P_W
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  fm_receiver_mul_arbiter_if.slave  bus
);

  localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [c_PTR_W-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0]    w_grant;
  logic [c_PTR_W-1:0]    w_grant_idx;
  logic                  w_grant_any;
  logic signed [A_W-1:0] w_a;
  logic signed [B_W-1:0] w_b;
  fm_mul_tag_t           w_tag_in;
  logic                  w_out_valid;
  fm_mul_tag_t           w_tag_out;
  logic signed [P_W-1:0] w_p_out;
  logic [MUL_STAGES-1:0] w_stage_valid;
  logic                  w_unused_tag;

  // Search begins one past the last winner and wraps once around.
  always_comb begin
    int idx;
    w_grant     = '0;
    w_grant_idx = '0;
    w_grant_any = 1'b0;
    idx         = 0;
`ifdef FM_MUL_ARB_PRIO_EN
    if (bus.req_valid[0]) begin
      w_grant[0]  = 1'b1;
      w_grant_any = 1'b1;
    end
`endif
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(r_rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`ifdef FM_MUL_ARB_PRIO_EN
      if (!w_grant_any && idx != 0 && bus.req_valid[idx]) begin
`else
      if (!w_grant_any && bus.req_valid[idx]) begin
`endif
        w_grant[idx] = 1'b1;
        w_grant_idx  = c_PTR_W'(idx);
        w_grant_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_a = bus.req_a[i*A_W +: A_W];
        w_b = bus.req_b[i*B_W +: B_W];
      end
    end
  end

  assign bus.req_ready = w_grant & {NUM_REQ{ap_rst_n}};
  assign w_tag_in      = fm_mul_tag_t'(w_grant);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rr_ptr <= c_PTR_W'(NUM_REQ - 1);
    end else if (w_grant_any) begin
      r_rr_ptr <= w_grant_idx;
    end
  end

  fm_rx_mul_pipe #(
    .MUL_STAGES (MUL_STAGES),
    .A_W        (A_W),
    .B_W        (B_W),
    .P_W        (P_W)
  ) u_mul_pipe (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .i_valid       (w_grant_any),
    .i_tag         (w_tag_in),
    .i_a           (w_a),
    .i_b           (w_b),
    .o_valid       (w_out_valid),
    .o_tag         (w_tag_out),
    .o_p           (w_p_out),
    .o_stage_valid (w_stage_valid)
  );

  assign bus.res_valid = w_tag_out[NUM_REQ-1:0] & {NUM_REQ{w_out_valid}};
  assign bus.res_p     = w_p_out;
  assign bus.busy      = |w_stage_valid;
  assign w_unused_tag  = ^w_tag_out;

endmodule
`default_nettype wire

// File: tb/tb_fm_receiver_mul_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fm_receiver_mul_arbiter                                       |
// | Scoreboard bench for the shared multiplier arbiter.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_fm_receiver_mul_arbiter;

  localparam int c_NUM_REQ    = 4;
  localparam int c_MUL_STAGES = 3;
`ifdef FM_MUL_ARB_PRIO_EN
  localparam bit c_PRIO = 1'b1;
`else
  localparam bit c_PRIO = 1'b0;
`endif

  typedef struct {
    logic [3:0] tag;
    longint     p;
    int         due;
  } exp_t;

  logic ap_clk;
  logic ap_rst_n;
  int   r_cyc;
  int   r_vec_cnt;
  int   r_miss_cnt;
  exp_t sb [$];
  logic signed [15:0] op_a [c_NUM_REQ];
  logic signed [15:0] op_b [c_NUM_REQ];

  fm_receiver_mul_arbiter_if #(.NUM_REQ(c_NUM_REQ), .A_W(16), .B_W(16), .P_W(30)) bus ();

  fm_receiver_mul_arbiter #(
    .NUM_REQ    (c_NUM_REQ),
    .MUL_STAGES (c_MUL_STAGES),
    .A_W        (16),
    .B_W        (16),
    .P_W        (30)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial r_cyc = 0;
  always @(posedge ap_clk) r_cyc <= r_cyc + 1;

  task automatic chk_val(input string tag, input longint got, input longint exp);
    r_vec_cnt++;
    if (got !== exp) begin
      r_miss_cnt++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, r_cyc);
    end
  endtask

  // Full signed product, then keep the low 30 bits as a signed value.
  function automatic longint model(input logic signed [15:0] a, input logic signed [15:0] b);
    longint             full;
    logic signed [29:0] t;
    full = longint'(a) * longint'(b);
    t    = full[29:0];
    return longint'(t);
  endfunction

  task automatic set_op(input int i, input logic signed [15:0] a, input logic signed [15:0] b);
    op_a[i] = a;
    op_b[i] = b;
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
  endtask

  task automatic step(input logic [3:0] vld, input logic [3:0] exp_rdy);
    bus.req_valid = vld;
    @(negedge ap_clk);
    chk_val("req_ready", longint'(bus.req_ready), longint'(exp_rdy));
    for (int i = 0; i < c_NUM_REQ; i++) begin
      if (exp_rdy[i]) sb.push_back('{tag: exp_rdy, p: model(op_a[i], op_b[i]), due: r_cyc + c_MUL_STAGES});
    end
    @(posedge ap_clk);
    #1;
  endtask

  // Result monitor: every res_valid must match the head of the scoreboard.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (bus.res_valid != 4'b0000) begin
        if (sb.size() == 0) begin
          chk_val("spurious_res", longint'(bus.res_valid), 0);
        end else begin
          chk_val("res_tag", longint'(bus.res_valid), longint'(sb[0].tag));
          chk_val("res_p", longint'($signed(bus.res_p)), sb[0].p);
          chk_val("res_latency", longint'(r_cyc), longint'(sb[0].due));
          void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && sb[0].due <= r_cyc) begin
        chk_val("res_missing", longint'(bus.res_valid), longint'(sb[0].tag));
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] exp_g;
    r_vec_cnt     = 0;
    r_miss_cnt    = 0;
    ap_rst_n      = 1'b0;
    bus.req_valid = 4'b1111;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int i = 0; i < c_NUM_REQ; i++) set_op(i, 16'sd0, 16'sd0);

    // Reset state, with every requester asserting valid.
    repeat (2) @(negedge ap_clk);
    chk_val("rst_req_ready", longint'(bus.req_ready), 0);
    chk_val("rst_res_valid", longint'(bus.res_valid), 0);
    chk_val("rst_res_p", longint'(bus.res_p), 0);
    chk_val("rst_busy", longint'(bus.busy), 0);
    @(posedge ap_clk);
    #1;
    ap_rst_n      = 1'b1;
    bus.req_valid = 4'b0000;

    // Full contention: 0,1,2,3,0 back-to-back.
    set_op(0, 16'sd10, 16'sd20);
    set_op(1, -16'sd3, 16'sd4);
    set_op(2, 16'sd1234, -16'sd5678);
    set_op(3, -16'sd32768, 16'sd32767);
    for (int k = 0; k < 5; k++) begin
      exp_g = c_PRIO ? 4'b0001 : 4'(1 << (k % 4));
      step(4'b1111, exp_g);
    end
    repeat (4) step(4'b0000, 4'b0000);

    // Single request from requester 2.
    set_op(2, 16'sd300, -16'sd7);
    step(4'b0100, 4'b0100);
    repeat (4) step(4'b0000, 4'b0000);

    // Truncation corners: 2^30 wraps to 0; low 30 bits of -1073709056 are 32768.
    set_op(1, -16'sd32768, -16'sd32768);
    step(4'b0010, 4'b0010);
    set_op(1, 16'sd32767, -16'sd32768);
    step(4'b0010, 4'b0010);
    repeat (4) step(4'b0000, 4'b0000);

    // Idle gaps on requester 3, then busy must fall MUL_STAGES cycles later.
    set_op(3, -16'sd1111, 16'sd77);
    for (int k = 0; k < 3; k++) begin
      step(4'b1000, 4'b1000);
      if (k < 2) step(4'b0000, 4'b0000);
    end
    for (int k = 1; k <= 4; k++) begin
      bus.req_valid = 4'b0000;
      @(negedge ap_clk);
      chk_val("idle_ready", longint'(bus.req_ready), 0);
      chk_val("idle_busy", longint'(bus.busy), (k <= c_MUL_STAGES) ? 1 : 0);
      @(posedge ap_clk);
      #1;
    end

    // Requesters 0 and 1 both held valid.
    set_op(0, 16'sd5, -16'sd9);
    set_op(1, -16'sd250, -16'sd4);
    for (int k = 0; k < 4; k++) begin
      exp_g = (c_PRIO || (k % 2 == 0)) ? 4'b0001 : 4'b0010;
      step(4'b0011, exp_g);
    end
    repeat (4) step(4'b0000, 4'b0000);

    // Mid-flight reset discards three products and restores the pointer.
    set_op(3, 16'sd99, 16'sd99);
    repeat (3) step(4'b1000, 4'b1000);
    bus.req_valid = 4'b1111;
    ap_rst_n      = 1'b0;
    sb.delete();
    @(negedge ap_clk);
    chk_val("midrst_ready", longint'(bus.req_ready), 0);
    chk_val("midrst_busy", longint'(bus.busy), 0);
    chk_val("midrst_res_valid", longint'(bus.res_valid), 0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    step(4'b1111, 4'b0001);
    repeat (6) step(4'b0000, 4'b0000);
    chk_val("final_busy", longint'(bus.busy), 0);
    chk_val("sb_empty", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", r_vec_cnt, r_miss_cnt);
    $finish;
  end

endmodule
`default_nettype wire
